elbeth_memory_responder: RTL and testbench



---
 rtl/elbeth_memory_responder.sv | 125 ++++++++++++
 tb/tb_elbeth_memory_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elbeth_memory_responder.sv
// Single-port word memory slave with byte-lane writes, programmable wait states
// and a one-cycle ready/error response per accepted request.
module elbeth_memory_responder #(
  parameter int    ADDR_WIDTH  = 14,
  parameter int    DEPTH_WORDS = 4096,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_en,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [3:0]            mem_rw,
  input  logic [31:0]           mem_in_data,
  output logic [31:0]           mem_out_data,
  output logic                  mem_ready,
  output logic                  mem_error
);
  localparam int                  IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH_WORDS);
  localparam logic [3:0]          WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  logic [31:0] mem [DEPTH_WORDS];

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            rw_q, rw_d;
  logic [31:0]           data_q, data_d;
  logic [31:0]           out_q, out_d;
  logic                  ready_q, ready_d;
  logic                  error_q, error_d;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic [3:0]            req_rw;
  logic [31:0]           req_data;
  logic                  req_ok;
  logic                  we;

  function automatic logic legal_strobe(input logic [3:0] s);
    case (s)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100, 4'b1111: legal_strobe = 1'b1;
      default:                            legal_strobe = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    data_d   = data_q;
    out_d    = out_q;
    ready_d  = 1'b0;
    error_d  = 1'b0;
    // With zero wait states the write commits on the accepting edge, so the
    // request is taken straight from the ports while idle.
    req_addr = (state_q == S_IDLE) ? mem_addr    : addr_q;
    req_rw   = (state_q == S_IDLE) ? mem_rw      : rw_q;
    req_data = (state_q == S_IDLE) ? mem_in_data : data_q;
    req_ok   = legal_strobe(req_rw) && ({1'b0, req_addr} < DEPTH_L);
    unique case (state_q)
      S_IDLE: begin
        if (mem_en) begin
          addr_d  = mem_addr;
          rw_d    = mem_rw;
          data_d  = mem_in_data;
          cnt_d   = WS_LOAD;
          state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!mem_en)            state_d = S_IDLE;
        else if (cnt_q == 4'd0) state_d = S_RESP;
        else                    cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        ready_d = 1'b1;
        error_d = !req_ok;
        out_d   = (req_ok && req_rw == 4'b0000) ? mem[req_addr[IDX_W-1:0]] : 32'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    we = !rst && (state_q != S_RESP) && (state_d == S_RESP) && req_ok && (req_rw != 4'b0000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rw_q    <= 4'd0;
      data_q  <= 32'd0;
      out_q   <= 32'd0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      data_q  <= data_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  // Array is deliberately unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (req_rw[i]) mem[req_addr[IDX_W-1:0]][8*i +: 8] <= req_data[8*i +: 8];
      end
    end
  end

  assign mem_out_data = out_q;
  assign mem_ready    = ready_q;
  assign mem_error    = error_q;
endmodule

// File: tb/tb_elbeth_memory_responder.sv
// Bench: three responders (1, 3 and 0 wait states) driven by scenario tasks and
// randomized traffic, checked against a word-array reference model.
module tb_elbeth_memory_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [3];
  logic        en   [3];
  logic [13:0] addr [3];
  logic [3:0]  rw   [3];
  logic [31:0] wd   [3];
  logic [31:0] rd   [3];
  logic        rdy  [3];
  logic        err  [3];

  int checks   = 0;
  int failures = 0;

  // Model only tracks words 0..15; out-of-range requests never touch it.
  logic [31:0] ref_mem [3][16];

  elbeth_memory_responder #(.ADDR_WIDTH(14), .DEPTH_WORDS(4096), .WAIT_STATES(1), .INIT_FILE("")) u0 (
    .clk(clk), .rst(rst[0]), .mem_en(en[0]), .mem_addr(addr[0]), .mem_rw(rw[0]),
    .mem_in_data(wd[0]), .mem_out_data(rd[0]), .mem_ready(rdy[0]), .mem_error(err[0]));
  elbeth_memory_responder #(.ADDR_WIDTH(14), .DEPTH_WORDS(4096), .WAIT_STATES(3), .INIT_FILE("")) u1 (
    .clk(clk), .rst(rst[1]), .mem_en(en[1]), .mem_addr(addr[1]), .mem_rw(rw[1]),
    .mem_in_data(wd[1]), .mem_out_data(rd[1]), .mem_ready(rdy[1]), .mem_error(err[1]));
  elbeth_memory_responder #(.ADDR_WIDTH(14), .DEPTH_WORDS(4096), .WAIT_STATES(0), .INIT_FILE("")) u2 (
    .clk(clk), .rst(rst[2]), .mem_en(en[2]), .mem_addr(addr[2]), .mem_rw(rw[2]),
    .mem_in_data(wd[2]), .mem_out_data(rd[2]), .mem_ready(rdy[2]), .mem_error(err[2]));

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 0;
  endfunction

  function automatic bit legal(input logic [3:0] s);
    return s inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
  endfunction

  // One request held until ready; checks latency, data, error and pulse width.
  task automatic txn(input int k, input logic [13:0] a, input logic [3:0] s, input logic [31:0] d,
                     input bit scramble, output logic [31:0] od, output logic oe);
    logic [31:0] exp_d;
    logic        exp_e;
    int          lat;
    exp_e = !legal(s) || (int'(a) >= 4096);
    exp_d = 32'd0;
    if (!exp_e) begin
      if (s == 4'h0) exp_d = ref_mem[k][a[3:0]];
      else for (int i = 0; i < 4; i++) if (s[i]) ref_mem[k][a[3:0]][8*i +: 8] = d[8*i +: 8];
    end
    @(negedge clk);
    en[k] = 1'b1; addr[k] = a; rw[k] = s; wd[k] = d;
    @(posedge clk); #1;
    if (scramble) begin
      addr[k] = 14'($urandom); rw[k] = 4'($urandom); wd[k] = $urandom;
    end
    lat = 0;
    while (!rdy[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    od = rd[k]; oe = err[k];
    en[k] = 1'b0;
    checks++;
    if (lat !== ws_of(k) + 1) begin
      failures++;
      $display("FAIL txn_latency inst=%0d addr=%0d rw=%b got=%0d exp=%0d", k, a, s, lat, ws_of(k) + 1);
    end
    checks++;
    if (oe !== exp_e) begin
      failures++;
      $display("FAIL txn_error inst=%0d addr=%0d rw=%b got=%b exp=%b", k, a, s, oe, exp_e);
    end
    checks++;
    if (od !== exp_d) begin
      failures++;
      $display("FAIL txn_data inst=%0d addr=%0d rw=%b got=%h exp=%h", k, a, s, od, exp_d);
    end
    @(posedge clk); #1;
    checks++;
    if (rdy[k] !== 1'b0) begin
      failures++;
      $display("FAIL txn_ready_width inst=%0d addr=%0d got=%b exp=0", k, a, rdy[k]);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; en[k] = 1'b0; addr[k] = '0; rw[k] = '0; wd[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({rdy[k], err[k], rd[k]} !== 34'd0) begin
        failures++;
        $display("FAIL reset_outputs inst=%0d got rdy=%b err=%b data=%h exp all 0", k, rdy[k], err[k], rd[k]);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
  endtask

  task automatic test_fill(input int k);
    logic [31:0] od;
    logic        oe;
    for (int a = 0; a < 16; a++) txn(k, 14'(a), 4'hF, $urandom, 1'b0, od, oe);
  endtask

  task automatic test_read_basic();
    logic [31:0] od;
    logic        oe;
    txn(0, 14'd5, 4'hF, 32'hDEADBEEF, 1'b0, od, oe);
    txn(0, 14'd5, 4'h0, 32'h0, 1'b0, od, oe);
    checks++;
    if (od !== 32'hDEADBEEF || oe !== 1'b0) begin
      failures++;
      $display("FAIL read_basic got=%h err=%b exp=deadbeef err=0", od, oe);
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] od;
    logic        oe;
    txn(0, 14'd7, 4'hF, 32'h12345678, 1'b0, od, oe);
    txn(0, 14'd7, 4'h2, 32'h0000AB00, 1'b0, od, oe);
    txn(0, 14'd7, 4'h0, 32'h0, 1'b0, od, oe);
    checks++;
    if (od !== 32'h1234AB78) begin
      failures++;
      $display("FAIL byte_write got=%h exp=1234ab78", od);
    end
  endtask

  task automatic test_errors();
    logic [31:0] od, pre;
    logic        oe;
    txn(0, 14'd4096, 4'h0, 32'h0, 1'b0, od, oe);
    checks++;
    if (oe !== 1'b1 || od !== 32'd0) begin
      failures++;
      $display("FAIL err_range got err=%b data=%h exp err=1 data=0", oe, od);
    end
    pre = ref_mem[0][3];
    txn(0, 14'd3, 4'b0101, 32'hFFFFFFFF, 1'b0, od, oe);
    checks++;
    if (oe !== 1'b1) begin
      failures++;
      $display("FAIL err_strobe got err=%b exp=1", oe);
    end
    txn(0, 14'd3, 4'h0, 32'h0, 1'b0, od, oe);
    checks++;
    if (od !== pre) begin
      failures++;
      $display("FAIL err_no_write got=%h exp=%h", od, pre);
    end
  endtask

  task automatic test_abort();
    logic [31:0] od, pre;
    logic        oe;
    int          seen;
    pre = ref_mem[1][9];
    @(negedge clk);
    en[1] = 1'b1; addr[1] = 14'd9; rw[1] = 4'hF; wd[1] = ~pre;
    @(posedge clk);
    @(posedge clk); #1;
    en[1] = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rdy[1]) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_no_ready got=%0d pulses exp=0", seen);
    end
    txn(1, 14'd9, 4'h0, 32'h0, 1'b0, od, oe);
    checks++;
    if (od !== pre) begin
      failures++;
      $display("FAIL abort_no_write got=%h exp=%h", od, pre);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] od;
    logic        oe;
    txn(1, 14'd9, 4'hF, 32'hA5A50001, 1'b0, od, oe);
    txn(1, 14'd9, 4'h0, 32'h0, 1'b0, od, oe);
    @(negedge clk);
    en[1] = 1'b1; addr[1] = 14'd9; rw[1] = 4'hF; wd[1] = 32'h5A5AFFFE;
    @(posedge clk);
    @(posedge clk); #3;
    checks++;
    if (rd[1] !== 32'hA5A50001) begin
      failures++;
      $display("FAIL areset_pre_data got=%h exp=a5a50001", rd[1]);
    end
    rst[1] = 1'b1;
    #1;
    checks++;
    if ({rdy[1], err[1], rd[1]} !== 34'd0) begin
      failures++;
      $display("FAIL areset_immediate got rdy=%b err=%b data=%h exp all 0", rdy[1], err[1], rd[1]);
    end
    en[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    txn(1, 14'd9, 4'h0, 32'h0, 1'b0, od, oe);
    checks++;
    if (od !== 32'hA5A50001) begin
      failures++;
      $display("FAIL areset_discard got=%h exp=a5a50001", od);
    end
  endtask

  task automatic test_random(input int k, input int n);
    logic [31:0] od;
    logic        oe;
    logic [13:0] a;
    logic [3:0]  s;
    for (int i = 0; i < n; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 14'(4096 + $urandom_range(0, 12000)) : 14'($urandom_range(0, 15));
      s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      txn(k, a, s, $urandom, 1'b1, od, oe);
    end
  endtask

  task automatic test_back_to_back();
    int n, cyc, extra;
    @(negedge clk);
    en[2] = 1'b1; addr[2] = 14'd0; rw[2] = 4'h0; wd[2] = 32'h0;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (rdy[2]) begin
        checks++;
        if (cyc !== 2 * (n + 1)) begin
          failures++;
          $display("FAIL b2b_spacing resp=%0d got cycle=%0d exp=%0d", n, cyc, 2 * (n + 1));
        end
        checks++;
        if (rd[2] !== ref_mem[2][n] || err[2] !== 1'b0) begin
          failures++;
          $display("FAIL b2b_data addr=%0d got=%h err=%b exp=%h err=0", n, rd[2], err[2], ref_mem[2][n]);
        end
        n++;
        if (n < 3) addr[2] = 14'(n);
        else       en[2] = 1'b0;
      end
    end
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=3", n);
    end
    en[2] = 1'b0;
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rdy[2]) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL b2b_extra got=%0d exp=0", extra);
    end
  endtask

  initial begin
    test_reset();
    for (int k = 0; k < 3; k++) test_fill(k);
    test_read_basic();
    test_byte_write();
    test_errors();
    test_abort();
    test_async_reset();
    test_random(0, 40);
    test_random(1, 20);
    test_random(2, 40);
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
